// File: rtl/iot601x_reader.sv
// PR8-E high-speed paper-tape reader, IOT device 01 (6011 RSF, 6012 RRB, 6014 RFC).
// Define RDR_IRQENA_EN to make irq-enable a register that 6010 sets and CLEAR clears.
module iot601x_reader #(
  parameter int unsigned BUFW      = 8,
  parameter bit          AUTOSTART = 1'b0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            CLEAR,
  input  logic            EN,
  input  logic [2:0]      IR,
  input  logic            ck1,
  input  logic            ck2,
  input  logic            ck3,
  input  logic            stb1,
  input  logic            stb2,
  input  logic            stb3,
  input  logic [BUFW-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            done,
  output logic            pc_ck,
  output logic            rot2ac,
  output logic            ac_ck,
  output logic [11:0]     ACRDR,
  output logic            irq,
  output logic            flag,
  output logic [11:0]     count
);

  localparam int unsigned ACW = 12;
  localparam int unsigned CW  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } st_e;

  st_e             st_q, st_d;
  logic [BUFW-1:0] rbuf_q, rbuf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            irqena;

  // Micro-op qualifiers; reset forces every instruction-derived output low at once.
  logic live, do_rsf, do_rrb_ck, do_rrb_stb, do_rfc, do_done, accept;

  assign live       = RESET_N & EN;
  assign do_rsf     = live & IR[0] & ck1 & stb1;
  assign do_rrb_ck  = live & IR[1] & ck2;
  assign do_rrb_stb = do_rrb_ck & stb2;
  assign do_done    = live & ck3 & stb3;
  assign do_rfc     = do_done & IR[2];
  assign accept     = in_valid & (st_q == REQ);

`ifdef RDR_IRQENA_EN
  logic irqena_q, irqena_d;
  logic do_rpe;

  assign do_rpe   = do_done & (IR == 3'b000);
  assign irqena_d = CLEAR ? 1'b0 : (do_rpe ? 1'b1 : irqena_q);
  assign irqena   = irqena_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) irqena_q <= 1'b1;
    else          irqena_q <= irqena_d;
  end
`else
  assign irqena = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      if (AUTOSTART) st_q <= REQ;
      else           st_q <= IDLE;
      rbuf_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      rbuf_q <= rbuf_d;
      cnt_q  <= cnt_d;
    end
  end

  // RFC overrides a coincident accept; the byte is still kept and counted.
  always_comb begin
    st_d   = st_q;
    rbuf_d = rbuf_q;
    cnt_d  = cnt_q;
    if (CLEAR) begin
      st_d = IDLE;
    end else begin
      if (accept) begin
        rbuf_d = in_data;
        cnt_d  = cnt_q + CW'(1);
      end
      if (do_rfc)                          st_d = REQ;
      else if (accept)                     st_d = FULL;
      else if (do_rrb_stb && st_q == FULL) st_d = IDLE;
    end
  end

  always_comb begin
    in_ready = (st_q == REQ);
    flag     = (st_q == FULL);
    irq      = flag & irqena;
    count    = cnt_q;
    pc_ck    = do_rsf & flag;
    rot2ac   = do_rrb_ck;
    ac_ck    = do_rrb_stb;
    ACRDR    = do_rrb_ck ? ACW'(rbuf_q) : '0;
    done     = do_done;
  end

endmodule

// File: tb/tb_iot601x_reader.sv
// Randomized bench for iot601x_reader against a flag/request-level model of the reader.
module tb_iot601x_reader;

  localparam int unsigned BUFW      = 8;
  localparam bit          AUTOSTART = 1'b0;

  logic            CLK = 1'b0;
  logic            RESET_N, CLEAR, EN;
  logic [2:0]      IR;
  logic            ck1, ck2, ck3, stb1, stb2, stb3;
  logic [BUFW-1:0] in_data;
  logic            in_valid;
  logic            in_ready, done, pc_ck, rot2ac, ac_ck, irq, flag;
  logic [11:0]     ACRDR, count;

  always #5 CLK = ~CLK;

  iot601x_reader #(.BUFW(BUFW), .AUTOSTART(AUTOSTART)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .EN(EN), .IR(IR),
    .ck1(ck1), .ck2(ck2), .ck3(ck3), .stb1(stb1), .stb2(stb2), .stb3(stb3),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .done(done), .pc_ck(pc_ck), .rot2ac(rot2ac), .ac_ck(ac_ck),
    .ACRDR(ACRDR), .irq(irq), .flag(flag), .count(count)
  );

  // Reader model: "is requesting", "holds a char", the char, the tally, irq-enable.
  logic            m_req, m_flag, m_ena;
  logic [BUFW-1:0] m_buf;
  logic [11:0]     m_cnt;
  logic            m_acc, m_rfc, m_rrb, m_rpe;

  assign m_acc = in_valid && m_req;
  assign m_rfc = EN && IR[2] && stb3;
  assign m_rrb = EN && IR[1] && stb2;
  assign m_rpe = EN && (IR == 3'b000) && stb3;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_req  <= AUTOSTART;
      m_flag <= 1'b0;
      m_ena  <= 1'b1;
      m_buf  <= '0;
      m_cnt  <= '0;
    end else begin
      m_flag <= !CLEAR && !m_rfc && (m_acc || (m_flag && !m_rrb));
      m_req  <= !CLEAR && (m_rfc || (m_req && !m_acc));
      if (!CLEAR && m_acc) begin
        m_buf <= in_data;
        m_cnt <= m_cnt + 12'd1;
      end
`ifdef RDR_IRQENA_EN
      m_ena <= !CLEAR && (m_ena || m_rpe);
`endif
    end
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          pc_n = 0, ac_n = 0, done_n = 0;
  logic [11:0] last_acr = '0;
  bit          rnd = 1'b0;
  bit          chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic live, e_rot;
    live  = RESET_N && EN;
    e_rot = live && IR[1] && ck2;
    check("in_ready", 32'(in_ready), 32'(m_req));
    check("flag",     32'(flag),     32'(m_flag));
    check("irq",      32'(irq),      32'(m_flag && m_ena));
    check("count",    32'(count),    32'(m_cnt));
    check("pc_ck",    32'(pc_ck),    32'(live && IR[0] && stb1 && m_flag));
    check("rot2ac",   32'(rot2ac),   32'(e_rot));
    check("ac_ck",    32'(ac_ck),    32'(live && IR[1] && stb2));
    check("ACRDR",    32'(ACRDR),    e_rot ? 32'(m_buf) : 32'd0);
    check("done",     32'(done),     32'(live && stb3));
  endtask

  // One cycle: compare at the falling edge, then move to just after the rising edge.
  task automatic tick();
    @(negedge CLK);
    if (chk_on) compare_all();
    if (pc_ck)  pc_n++;
    if (ac_ck)  ac_n++;
    if (done)   done_n++;
    if (rot2ac) last_acr = ACRDR;
    @(posedge CLK);
    #1;
    if (rnd) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = BUFW'($urandom);
      CLEAR    = ($urandom_range(0, 31) == 0);
    end
  endtask

  task automatic do_iot(input logic [2:0] ir);
    EN = 1'b1;
    IR = ir;
    for (int s = 1; s <= 3; s++) begin
      for (int c = 0; c < 3; c++) begin
        ck1  = (s == 1);
        ck2  = (s == 2);
        ck3  = (s == 3);
        stb1 = (s == 1) && (c == 1);
        stb2 = (s == 2) && (c == 1);
        stb3 = (s == 3) && (c == 1);
        tick();
      end
    end
    EN = 1'b0; IR = 3'b000;
    ck1 = 1'b0; ck2 = 1'b0; ck3 = 1'b0;
    stb1 = 1'b0; stb2 = 1'b0; stb3 = 1'b0;
  endtask

  task automatic send_byte(input logic [BUFW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  int p0, a0, d0;

  initial begin
    CLEAR = 0; EN = 0; IR = 0; in_data = 0; in_valid = 0;
    ck1 = 0; ck2 = 0; ck3 = 0; stb1 = 0; stb2 = 0; stb3 = 0;
    RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    chk_on = 1'b1;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_flag",     32'(flag),     32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_acrdr",    32'(ACRDR),    32'd0);
    RESET_N = 1'b1;
    tick();

    // RFC, then a byte fills the buffer; RSF must skip once.
    do_iot(3'b100);
    check("rfc_ready", 32'(in_ready), 32'd1);
    send_byte(8'h5A);
    check("5a_ready", 32'(in_ready), 32'd0);
    check("5a_flag",  32'(flag),     32'd1);
    check("5a_count", 32'(count),    32'h001);
    p0 = pc_n;
    do_iot(3'b001);
    check("rsf_skip", 32'(pc_n - p0), 32'd1);

    // RRB of 0xA5, then RSF must not skip.
    do_iot(3'b100);
    send_byte(8'hA5);
    a0 = ac_n;
    do_iot(3'b010);
    check("rrb_acrdr", 32'(last_acr),  32'o0245);
    check("rrb_ac_ck", 32'(ac_n - a0), 32'd1);
    check("rrb_flag",  32'(flag),      32'd0);
    p0 = pc_n;
    do_iot(3'b001);
    check("rsf_noskip", 32'(pc_n - p0), 32'd0);

    // 6016: read current char, re-request, then 0xFF arrives.
    do_iot(3'b100);
    send_byte(8'h33);
    do_iot(3'b110);
    check("6016_acrdr", 32'(last_acr), 32'h033);
    check("6016_ready", 32'(in_ready), 32'd1);
    check("6016_flag",  32'(flag),     32'd0);
    send_byte(8'hFF);
    check("ff_flag", 32'(flag), 32'd1);
    do_iot(3'b010);
    check("ff_acrdr", 32'(last_acr), 32'h0FF);
    check("ff_count", 32'(count),    32'h004);

    // CLEAR coincident with a handshake discards the byte.
    do_iot(3'b100);
    CLEAR = 1'b1;
    send_byte(8'h77);
    CLEAR = 1'b0;
    check("clr_ready", 32'(in_ready), 32'd0);
    check("clr_flag",  32'(flag),     32'd0);
    check("clr_count", 32'(count),    32'h004);

    // irq gating after CLEAR; 6010 always completes.
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    do_iot(3'b100);
    send_byte(8'h11);
`ifdef RDR_IRQENA_EN
    check("clr_irq", 32'(irq), 32'd0);
`else
    check("clr_irq", 32'(irq), 32'd1);
`endif
    d0 = done_n;
    do_iot(3'b000);
    check("rpe_irq",  32'(irq),         32'd1);
    check("rpe_done", 32'(done_n - d0), 32'd1);

    // Count wrap: 4095 accepts to 7777, one more to 0000.
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    EN = 1'b1; IR = 3'b100; ck3 = 1'b1; stb3 = 1'b1; in_data = 8'h3C;
    tick();
    for (int i = 0; i < 4095; i++) begin
      in_valid = 1'b1; stb3 = 1'b0;
      tick();
      in_valid = 1'b0; stb3 = 1'b1;
      tick();
    end
    check("wrap_7777", 32'(count),    32'o7777);
    check("wrap_req",  32'(in_ready), 32'd1);
    in_valid = 1'b1; stb3 = 1'b0;
    tick();
    in_valid = 1'b0;
    check("wrap_0000", 32'(count), 32'd0);
    check("wrap_flag", 32'(flag),  32'd1);
    EN = 1'b0; IR = 3'b000; ck3 = 1'b0;
    tick();

    // Reset in the middle of ck2 of an RRB.
    EN = 1'b1; IR = 3'b010;
    ck1 = 1'b1;
    repeat (3) tick();
    ck1 = 1'b0; ck2 = 1'b1;
    tick();
    check("pre_rot2ac", 32'(rot2ac), 32'd1);
    check("pre_acrdr",  32'(ACRDR),  32'h03C);
    #2 RESET_N = 1'b0;
    #1;
    check("ar_rot2ac", 32'(rot2ac),   32'd0);
    check("ar_acrdr",  32'(ACRDR),    32'd0);
    check("ar_ac_ck",  32'(ac_ck),    32'd0);
    check("ar_flag",   32'(flag),     32'd0);
    check("ar_irq",    32'(irq),      32'd0);
    check("ar_count",  32'(count),    32'd0);
    check("ar_ready",  32'(in_ready), 32'd0);
    d0 = done_n;
    stb2 = 1'b1; tick(); stb2 = 1'b0; tick();
    ck2 = 1'b0; ck3 = 1'b1; tick();
    stb3 = 1'b1; tick(); stb3 = 1'b0; tick();
    check("ar_no_done", 32'(done_n - d0), 32'd0);
    EN = 1'b0; IR = 3'b000; ck3 = 1'b0;
    RESET_N = 1'b1;
    tick();

    // Random instructions against a random byte source and sporadic CLEAR.
    rnd = 1'b1;
    repeat (300) begin
      do_iot(3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd = 1'b0;
    in_valid = 1'b0; CLEAR = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
